// File: rtl/tl_phase_sched.sv
// tl_phase_sched: phase scheduler for the highway/country-road junction.
// Latency: every output is registered; phase, lamps, remain and walk update one clk after a tick.
// Backpressure: none; the block only advances on the 1 Hz tick and never stalls its inputs.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset (reset wins over tick)
//   tick         one-clk 1 Hz enable that advances the phase down-counter
//   c_sensor     country-road vehicle present (sampled only on tick cycles)
//   ped_req      pedestrian button, level or pulse (used only with PED_CROSS_EN)
//   phase        0=MGCR 1=MYCR 2=MRCG 3=MRCY
//   main_light   main-road head {red,yellow,green}, one-hot
//   ctry_light   country-road head {red,yellow,green}, one-hot
//   remain       ticks left in the current phase, for the countdown display
//   phase_done   one-clk pulse accompanying each phase change
//   ped_walk     walk lamp
// Optional feature: define PED_CROSS_EN to enable the pedestrian crossing request/walk logic.
module tl_phase_sched #(
  parameter int unsigned T_MAIN_GREEN = 60,
  parameter int unsigned T_YELLOW     = 4,
  parameter int unsigned T_CTRY_GREEN = 20,
  parameter int unsigned T_PED        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       c_sensor,
  input  logic       ped_req,
  output logic [1:0] phase,
  output logic [2:0] main_light,
  output logic [2:0] ctry_light,
  output logic [5:0] remain,
  output logic       phase_done,
  output logic       ped_walk
);

  typedef enum logic [1:0] {
    MGCR = 2'd0,
    MYCR = 2'd1,
    MRCG = 2'd2,
    MRCY = 2'd3
  } phase_e;

  localparam logic [5:0] L_MAIN = 6'(T_MAIN_GREEN);
  localparam logic [5:0] L_YEL  = 6'(T_YELLOW);
  localparam logic [5:0] L_CTRY = 6'(T_CTRY_GREEN);

  phase_e     phase_q, phase_d;
  logic [5:0] remain_q, remain_d;
  logic [2:0] main_q, main_d;
  logic [2:0] ctry_q, ctry_d;
  logic       done_q, done_d;
  logic       want_ped;   // pending pedestrian request forces a country phase
  logic       hold_walk;  // an active walk keeps MRCG from terminating early

`ifdef PED_CROSS_EN
  localparam logic [5:0] L_PED = 6'(T_PED);
  logic       ped_pending_q, ped_pending_d;
  logic       ped_walk_q, ped_walk_d;
  logic [5:0] walk_cnt_q, walk_cnt_d;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  // Phase sequencing and down-counter
  always_comb begin
    phase_d   = phase_q;
    remain_d  = remain_q;
    want_ped  = 1'b0;
    hold_walk = 1'b0;
`ifdef PED_CROSS_EN
    want_ped  = ped_pending_q;
    hold_walk = ped_walk_q;
`endif
    if (tick) begin
      unique case (phase_q)
        MGCR: begin
          if (remain_q != 6'd1) begin
            remain_d = remain_q - 6'd1;
          end else if (c_sensor || want_ped) begin
            phase_d  = MYCR;
            remain_d = L_YEL;
          end else begin
            // Nobody waiting: main green simply recycles.
            remain_d = L_MAIN;
          end
        end
        MYCR: begin
          if (remain_q != 6'd1) begin
            remain_d = remain_q - 6'd1;
          end else begin
            phase_d  = MRCG;
            remain_d = L_CTRY;
          end
        end
        MRCG: begin
          if (remain_q == 6'd1 || (!c_sensor && !hold_walk)) begin
            phase_d  = MRCY;
            remain_d = L_YEL;
          end else begin
            remain_d = remain_q - 6'd1;
          end
        end
        MRCY: begin
          if (remain_q != 6'd1) begin
            remain_d = remain_q - 6'd1;
          end else begin
            phase_d  = MGCR;
            remain_d = L_MAIN;
          end
        end
        default: ;
      endcase
    end
  end

  // Lamps follow the next phase so they change in the same clk as phase.
  always_comb begin
    main_d = 3'b100;
    ctry_d = 3'b100;
    unique case (phase_d)
      MGCR: begin main_d = 3'b001; ctry_d = 3'b100; end
      MYCR: begin main_d = 3'b010; ctry_d = 3'b100; end
      MRCG: begin main_d = 3'b100; ctry_d = 3'b001; end
      MRCY: begin main_d = 3'b100; ctry_d = 3'b010; end
      default: ;
    endcase
    done_d = (phase_d != phase_q);
  end

`ifdef PED_CROSS_EN
  // Pedestrian request latch and walk timer
  always_comb begin
    ped_pending_d = ped_pending_q | ped_req;
    ped_walk_d    = ped_walk_q;
    walk_cnt_d    = walk_cnt_q;
    if (tick && phase_q == MRCG && walk_cnt_q != 6'd0) begin
      walk_cnt_d = walk_cnt_q - 6'd1;
      if (walk_cnt_q == 6'd1) ped_walk_d = 1'b0;
    end
    if (phase_d == MRCG && phase_q != MRCG) begin
      // Entering MRCG serves every request seen so far, including this clk's.
      ped_pending_d = 1'b0;
      ped_walk_d    = 1'b1;
      walk_cnt_d    = L_PED;
    end else if (phase_d != MRCG) begin
      ped_walk_d = 1'b0;
      walk_cnt_d = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_pending_q <= 1'b0;
      ped_walk_q    <= 1'b0;
      walk_cnt_q    <= 6'd0;
    end else begin
      ped_pending_q <= ped_pending_d;
      ped_walk_q    <= ped_walk_d;
      walk_cnt_q    <= walk_cnt_d;
    end
  end

  assign ped_walk = ped_walk_q;
`else
  assign ped_walk = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= MGCR;
      remain_q <= L_MAIN;
      main_q   <= 3'b001;
      ctry_q   <= 3'b100;
      done_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      remain_q <= remain_d;
      main_q   <= main_d;
      ctry_q   <= ctry_d;
      done_q   <= done_d;
    end
  end

  assign phase      = phase_q;
  assign remain     = remain_q;
  assign main_light = main_q;
  assign ctry_light = ctry_q;
  assign phase_done = done_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// tb_tl_phase_sched: randomized and directed bench for the junction phase scheduler.
// Latency: compares all outputs once per clk against a tick-level reference model.
// Backpressure: none; stimulus is free-running.
module tb_tl_phase_sched;

  localparam int T_MG = 60;
  localparam int T_Y  = 4;
  localparam int T_CG = 20;
  localparam int T_PD = 10;
`ifdef PED_CROSS_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       c_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] phase;
  logic [2:0] main_light;
  logic [2:0] ctry_light;
  logic [5:0] remain;
  logic       phase_done;
  logic       ped_walk;

  tl_phase_sched dut (
    .clk(clk), .rst(rst), .tick(tick), .c_sensor(c_sensor), .ped_req(ped_req),
    .phase(phase), .main_light(main_light), .ctry_light(ctry_light),
    .remain(remain), .phase_done(phase_done), .ped_walk(ped_walk)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  // Reference model: phase index, ticks left, pedestrian state
  int m_phase, m_remain, m_wcnt;
  bit m_pend, m_walk, m_done;
  int         dur[4]      = '{T_MG, T_Y, T_CG, T_Y};
  logic [2:0] main_tab[4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] ctry_tab[4] = '{3'b100, 3'b100, 3'b001, 3'b010};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input bit cs, input bit pr);
    int nph, nrem;
    bit early;
    if (r) begin
      m_phase = 0; m_remain = T_MG; m_pend = 0; m_walk = 0; m_wcnt = 0; m_done = 0;
      return;
    end
    nph = m_phase;
    nrem = m_remain;
    if (t) begin
      early = (m_phase == 2) && !cs && !m_walk;
      if (m_remain == 1 || early) begin
        if (m_phase == 0 && !(cs || m_pend)) nrem = T_MG;
        else begin
          nph = (m_phase + 1) % 4;
          nrem = dur[nph];
        end
      end else begin
        nrem = m_remain - 1;
      end
      if (m_phase == 2 && m_wcnt > 0) begin
        m_wcnt--;
        if (m_wcnt == 0) m_walk = 0;
      end
    end
    if (PED && pr) m_pend = 1;
    if (PED && nph == 2 && m_phase != 2) begin
      m_pend = 0; m_walk = 1; m_wcnt = T_PD;
    end
    if (nph != 2) m_walk = 0;
    m_done = (nph != m_phase);
    m_phase = nph;
    m_remain = nrem;
  endtask

  task automatic compare_all();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("remain", 32'(remain), 32'(m_remain));
    chk("main_light", 32'(main_light), 32'(main_tab[m_phase]));
    chk("ctry_light", 32'(ctry_light), 32'(ctry_tab[m_phase]));
    chk("phase_done", 32'(phase_done), 32'(m_done));
    chk("ped_walk", 32'(ped_walk), 32'(m_walk));
    chk("main_onehot", 32'($onehot(main_light)), 32'd1);
    chk("ctry_onehot", 32'($onehot(ctry_light)), 32'd1);
    chk("one_head_red", 32'(main_light[2] | ctry_light[2]), 32'd1);
    if (phase_done === 1'b1) done_cnt++;
  endtask

  task automatic cyc(input bit r, input bit t, input bit cs, input bit pr);
    rst = r; tick = t; c_sensor = cs; ped_req = pr;
    @(posedge clk);
    model_step(r, t, cs, pr);
    @(negedge clk);
    compare_all();
  endtask

  // A few idle clks (sensor/button still driven) followed by one tick clk.
  task automatic do_tick(input bit cs, input bit pr);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0, cs, 1'b0);
    cyc(1'b0, 1'b1, cs, pr);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int k;
    bit cs_r;

    // 1: idle country road, main green recycles, no phase changes
    do_reset();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_remain", 32'(remain), 32'(T_MG));
    chk("rst_done", 32'(phase_done), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 130; i++) do_tick(1'b0, 1'b0);
    chk("t1_no_done", 32'(done_cnt), 32'd0);
    chk("t1_remain", 32'(remain), 32'(T_MG - 10));

    // 2: country car always present, one full cycle
    do_reset();
    done_cnt = 0;
    for (int i = 0; i < T_MG + T_Y + T_CG + T_Y; i++) do_tick(1'b1, 1'b0);
    chk("t2_done_pulses", 32'(done_cnt), 32'd4);
    chk("t2_back_mgcr", 32'(phase), 32'd0);
    chk("t2_reload", 32'(remain), 32'(T_MG));

    // 3: car leaves after 5 ticks of country green -> early yellow
    do_reset();
    k = 0;
    while (!(m_phase == 2 && m_remain == T_CG - 5) && k < 200) begin
      do_tick(1'b1, 1'b0);
      k++;
    end
    chk("t3_reach_mrcg", 32'(k < 200), 32'd1);
    do_tick(1'b0, 1'b0);
    chk("t3_phase", 32'(phase), 32'd3);
    chk("t3_remain", 32'(remain), 32'(T_Y));

    // 4/5: single pedestrian press on tick 10 of main green
    do_reset();
    for (int i = 1; i <= T_MG; i++) do_tick(1'b0, i == 10);
`ifdef PED_CROSS_EN
    chk("t4_mycr", 32'(phase), 32'd1);
    for (int i = 0; i < T_Y; i++) do_tick(1'b0, 1'b0);
    chk("t4_mrcg", 32'(phase), 32'd2);
    chk("t4_walk_on", 32'(ped_walk), 32'd1);
    for (int i = 0; i < T_PD - 1; i++) do_tick(1'b0, 1'b0);
    chk("t4_walk_held", 32'(ped_walk), 32'd1);
    do_tick(1'b0, 1'b0);
    chk("t4_walk_end", 32'(ped_walk), 32'd0);
    chk("t4_still_mrcg", 32'(phase), 32'd2);
    do_tick(1'b0, 1'b0);
    chk("t4_mrcy", 32'(phase), 32'd3);
    chk("t4_walk_mrcy", 32'(ped_walk), 32'd0);
`else
    chk("t5_stay_mgcr", 32'(phase), 32'd0);
    chk("t5_no_walk", 32'(ped_walk), 32'd0);
`endif

    // 6: reset on a tick clk in the middle of country green
    do_reset();
    k = 0;
    while (!(m_phase == 2 && m_remain == T_CG - 8) && k < 200) begin
      do_tick(1'b1, 1'b0);
      k++;
    end
    chk("t6_reach_mrcg", 32'(k < 200), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_phase", 32'(phase), 32'd0);
    chk("t6_remain", 32'(remain), 32'(T_MG));
    chk("t6_walk", 32'(ped_walk), 32'd0);
    chk("t6_done", 32'(phase_done), 32'd0);

    // Randomized traffic: sticky sensor, sparse button presses, rare resets
    cs_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) cs_r = ~cs_r;
      cyc($urandom_range(0, 1499) == 0, $urandom_range(0, 2) == 0, cs_r,
          $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
